// File: rtl/gyro_rate_integrator_multi.sv
// gyro_rate_integrator_multi: per-channel zero-rate bias calibration, periodic wrapped integration and scaled angle output
module gyro_rate_integrator_multi #(
    parameter int                 NUM_CH        = 3,
    parameter int                 DATA_W        = 32,
    parameter int                 OUT_W         = 32,
    parameter int                 SETTLE_CYCLES = 50000000,
    parameter int                 AVG_LOG2      = 24,
    parameter int                 UPDATE_PERIOD = 196078,
    parameter int                 TURN_RAW      = 2880,
    parameter logic signed [15:0] SCALE_MUL     = 16'sd1,
    parameter int                 SCALE_SHIFT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     recalibrate,
    input  logic                     hold_zero,
    input  logic [NUM_CH*DATA_W-1:0] rate_in,
    output logic [NUM_CH*OUT_W-1:0]  angle_out,
    output logic                     angle_valid,
    output logic                     calibrated
);
    localparam int SW = DATA_W + AVG_LOG2 + 1;
    localparam int TW = $clog2(TURN_RAW) + 2;
    localparam int AW = TW > DATA_W + 2 ? TW : DATA_W + 2;
    localparam int PW = AW + 16 + OUT_W;
    localparam logic [31:0] S_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] A_LAST = 32'((64'd1 << AVG_LOG2) - 64'd1);
    localparam logic [31:0] P_LAST = 32'(UPDATE_PERIOD - 1);
    localparam logic [31:0] N_LAST = 32'(NUM_CH - 1);
    localparam logic signed [AW-1:0] HALF = AW'(TURN_RAW / 2);
    localparam logic signed [AW-1:0] TURN = AW'(TURN_RAW);

    typedef enum logic [1:0] {SETTLE, AVERAGE, RUN} state_t;

    state_t                   state;
    logic [31:0]              cnt;
    logic                     ticked;
    logic                     integ;
    logic signed [SW-1:0]     sum    [NUM_CH];
    logic signed [DATA_W-1:0] bias   [NUM_CH];
    logic signed [DATA_W-1:0] snap   [NUM_CH];
    logic signed [AW-1:0]     acc    [NUM_CH];
    logic signed [AW-1:0]     acc_nx [NUM_CH];

    // Single-step wrap into (-TURN_RAW/2, +TURN_RAW/2]; one step suffices because |delta| < TURN_RAW/2
    function automatic logic signed [AW-1:0] wrap(input logic signed [AW-1:0] a);
        return a > HALF ? a - TURN : (a <= -HALF ? a + TURN : a);
    endfunction

    function automatic logic [OUT_W-1:0] scale(input logic signed [AW-1:0] a);
        logic signed [PW-1:0] p;
        p = (PW'(a) * PW'(SCALE_MUL)) >>> SCALE_SHIFT;
        return OUT_W'(p);
    endfunction

    // Next accumulator values: channel c is swept while the post-tick counter equals c; hold_zero clears everything
    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            acc_nx[c] = hold_zero ? '0 :
                        (ticked && integ && cnt == 32'(c)) ? wrap(acc[c] + AW'(snap[c]) - AW'(bias[c])) : acc[c];
    end

    // Calibration / integration state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset || recalibrate) begin
            state       <= SETTLE;
            cnt         <= '0;
            ticked      <= 1'b0;
            integ       <= 1'b0;
            angle_valid <= 1'b0;
            calibrated  <= 1'b0;
            angle_out   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sum[c] <= '0;
                acc[c] <= '0;
                if (reset) begin
                    bias[c] <= '0;
                    snap[c] <= '0;
                end
            end
        end else begin
            angle_valid <= 1'b0;
            case (state)
                SETTLE: begin
                    cnt <= cnt == S_LAST ? '0 : cnt + 32'd1;
                    if (cnt == S_LAST) state <= AVERAGE;
                end
                AVERAGE: begin
                    cnt <= cnt == A_LAST ? '0 : cnt + 32'd1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        sum[c] <= sum[c] + SW'($signed(rate_in[c*DATA_W +: DATA_W]));
                        if (cnt == A_LAST)
                            bias[c] <= DATA_W'((sum[c] + SW'($signed(rate_in[c*DATA_W +: DATA_W]))) >>> AVG_LOG2);
                    end
                    if (cnt == A_LAST) begin
                        state      <= RUN;
                        calibrated <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt == P_LAST ? '0 : cnt + 32'd1;
                    for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nx[c];
                    if (cnt == P_LAST) begin
                        ticked <= 1'b1;
                        integ  <= !hold_zero;
                        for (int c = 0; c < NUM_CH; c++) snap[c] <= $signed(rate_in[c*DATA_W +: DATA_W]);
                    end
                    if (ticked && cnt == N_LAST) begin
                        ticked      <= 1'b0;
                        angle_valid <= 1'b1;
                        for (int c = 0; c < NUM_CH; c++) angle_out[c*OUT_W +: OUT_W] <= scale(acc_nx[c]);
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gyro_rate_integrator_multi.sv
// tb_gyro_rate_integrator_multi: directed and randomized checks of gyro_rate_integrator_multi against an edge-count reference model
module tb_gyro_rate_integrator_multi;
    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int OW   = 16;
    localparam int TURN = 1000;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          recalibrate = 1'b0;
    logic          hold_zero   = 1'b0;
    logic [N*DW-1:0] rate_in   = '0;
    logic [N*OW-1:0] out0, out1;
    logic          v0, v1, cal0, cal1;

    int n_vec = 0;
    int n_bad = 0;

    int k = 0;
    bit armed = 1'b0, integ = 1'b0, exp_cal = 1'b0, exp_valid = 1'b0;
    int sum[N], bias_m[N], acc[N], snap[N], exp_a[N], exp_s[N];

    always #5 clk = ~clk;

    gyro_rate_integrator_multi #(
        .NUM_CH(N), .DATA_W(DW), .OUT_W(OW), .SETTLE_CYCLES(4), .AVG_LOG2(2),
        .UPDATE_PERIOD(8), .TURN_RAW(TURN), .SCALE_MUL(16'sd1), .SCALE_SHIFT(0)
    ) u0 (
        .clk(clk), .reset(reset), .recalibrate(recalibrate), .hold_zero(hold_zero),
        .rate_in(rate_in), .angle_out(out0), .angle_valid(v0), .calibrated(cal0)
    );

    gyro_rate_integrator_multi #(
        .NUM_CH(N), .DATA_W(DW), .OUT_W(OW), .SETTLE_CYCLES(4), .AVG_LOG2(2),
        .UPDATE_PERIOD(8), .TURN_RAW(TURN), .SCALE_MUL(16'sd3), .SCALE_SHIFT(1)
    ) u1 (
        .clk(clk), .reset(reset), .recalibrate(recalibrate), .hold_zero(hold_zero),
        .rate_in(rate_in), .angle_out(out1), .angle_valid(v1), .calibrated(cal1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if (a % b != 0 && ((a < 0) != (b < 0))) q--;
        return q;
    endfunction

    function automatic int wrap(input int a);
        int r;
        r = a;
        while (r > TURN / 2) r -= TURN;
        while (r <= -(TURN / 2)) r += TURN;
        return r;
    endfunction

    function automatic int rate(input int c);
        logic signed [DW-1:0] s;
        s = rate_in[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic int ang(input logic [N*OW-1:0] v, input int c);
        logic signed [OW-1:0] s;
        s = v[c*OW +: OW];
        return int'(s);
    endfunction

    // k counts clock edges since the last reset/recalibrate edge: 1..4 settle, 5..8 average,
    // ticks every 8 edges from 16, results published three edges after each tick
    task automatic model_step();
        bit tick, pub;
        if (reset || recalibrate) begin
            k = 0; armed = 1'b1; exp_cal = 1'b0; exp_valid = 1'b0;
            for (int c = 0; c < N; c++) begin
                sum[c] = 0; acc[c] = 0; exp_a[c] = 0; exp_s[c] = 0;
                if (reset) bias_m[c] = 0;
            end
        end else begin
            k++;
            exp_valid = 1'b0;
            tick = k >= 16 && (k - 16) % 8 == 0;
            pub  = k >= 19 && (k - 19) % 8 == 0;
            for (int c = 0; c < N; c++) begin
                if (k >= 5 && k <= 8) sum[c] += rate(c);
                if (k == 8) bias_m[c] = fdiv(sum[c], 4);
                if (k >= 9 && hold_zero) acc[c] = 0;
                if (tick) snap[c] = rate(c);
            end
            if (k == 8) exp_cal = 1'b1;
            if (tick) integ = !hold_zero;
            if (pub) begin
                exp_valid = 1'b1;
                for (int c = 0; c < N; c++) begin
                    if (integ && !hold_zero) acc[c] = wrap(acc[c] + snap[c] - bias_m[c]);
                    exp_a[c] = acc[c];
                    exp_s[c] = fdiv(acc[c] * 3, 2);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every cycle after the first reset edge, both DUTs must match the model
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("calibrated", int'(cal0), int'(exp_cal));
            chk("calibrated_scaled", int'(cal1), int'(exp_cal));
            chk("angle_valid", int'(v0), int'(exp_valid));
            chk("angle_valid_scaled", int'(v1), int'(exp_valid));
            for (int c = 0; c < N; c++) begin
                chk($sformatf("angle_out[%0d]", c), ang(out0, c), exp_a[c]);
                chk($sformatf("angle_out_scaled[%0d]", c), ang(out1, c), exp_s[c]);
            end
        end
    end

    task automatic set_rates(input int r0, input int r1, input int r2);
        rate_in = {DW'(r2), DW'(r1), DW'(r0)};
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v0 && n < 40);
        if (!v0) begin
            n_vec++;
            n_bad++;
            $display("FAIL valid_timeout: angle_valid low for %0d cycles, expected a pulse", n);
        end
    endtask

    initial begin
        int n;
        int e1[4];
        int e2[4];
        int base[N];
        int r[N];
        e1 = '{250, 500, -250, 0};
        e2 = '{-250, 500, 250, 0};

        set_rates(100, -50, 7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (cal0) break;
        end
        chk("cal_latency", n, 8);
        wait_valid(n);
        chk("first_valid_delay", n, 11);
        for (int c = 0; c < N; c++) chk($sformatf("cal_zero[%0d]", c), ang(out0, c), 0);
        wait_valid(n);
        chk("valid_spacing", n, 8);

        set_rates(110, -50, 7);
        for (int i = 1; i <= 3; i++) begin
            wait_valid(n);
            chk("integrate_ch0", ang(out0, 0), 10 * i);
            chk("integrate_ch1", ang(out0, 1), 0);
            chk("integrate_ch2", ang(out0, 2), 0);
        end

        set_rates(100, 200, -243);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            chk("wrap_ch0", ang(out0, 0), 30);
            chk("wrap_ch1", ang(out0, 1), e1[i]);
            chk("wrap_ch2", ang(out0, 2), e2[i]);
        end

        set_rates(77, -50, 7);
        wait_valid(n);
        chk("scale_pos_raw", ang(out0, 0), 7);
        chk("scale_pos", ang(out1, 0), 10);
        set_rates(86, -50, 7);
        wait_valid(n);
        chk("scale_neg_raw", ang(out0, 0), -7);
        chk("scale_neg", ang(out1, 0), -11);

        set_rates(105, -50, 7);
        hold_zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            chk("hold_ch0", ang(out0, 0), 0);
        end
        hold_zero = 1'b0;
        wait_valid(n);
        chk("resume_ch0", ang(out0, 0), 5);
        wait_valid(n);
        chk("resume2_ch0", ang(out0, 0), 10);

        repeat (4) @(negedge clk);
        recalibrate = 1'b1;
        @(negedge clk);
        recalibrate = 1'b0;
        chk("recal_cal_drop", int'(cal0), 0);
        chk("recal_no_valid", int'(v0), 0);
        chk("recal_out_clear", ang(out0, 0), 0);
        repeat (4) @(negedge clk);
        set_rates(-1, -50, 7);
        @(negedge clk);
        set_rates(-2, -50, 7);
        @(negedge clk);
        set_rates(-1, -50, 7);
        @(negedge clk);
        set_rates(-2, -50, 7);
        chk("recal_not_yet", int'(cal0), 0);
        @(negedge clk);
        chk("recal_recover", int'(cal0), 1);
        chk("model_bias_floor", bias_m[0], -2);
        wait_valid(n);
        chk("recal_first_valid", n, 11);
        chk("neg_bias_ch0", ang(out0, 0), 0);
        wait_valid(n);
        chk("neg_bias2_ch0", ang(out0, 0), 0);

        for (int c = 0; c < N; c++) base[c] = int'($urandom_range(40000)) - 20000;
        recalibrate = 1'b1;
        @(negedge clk);
        recalibrate = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                r[c] = exp_cal ? bias_m[c] + int'($urandom_range(980)) - 490
                               : base[c] + int'($urandom_range(6)) - 3;
                rate_in[c*DW +: DW] = DW'(r[c]);
            end
            if (v0 && $urandom_range(3) == 0) hold_zero = ~hold_zero;
            recalibrate = $urandom_range(299) == 0;
            if (recalibrate)
                for (int c = 0; c < N; c++) base[c] = int'($urandom_range(40000)) - 20000;
            @(negedge clk);
        end
        recalibrate = 1'b0;
        hold_zero = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
